whack_scorer: RTL and testbench

//  Downstream consumer of the light controller: watches the 9 board buttons against the lit mole.

---
 rtl/whack_scorer_pkg.sv | 23 ++
 rtl/whack_scorer_if.sv | 29 ++
 rtl/whack_scorer_button_sync.sv | 30 +++
 rtl/whack_scorer.sv | 126 ++++++++++++
 tb/tb_whack_scorer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/whack_scorer_pkg.sv
// Shared definitions for the whack-a-mole scorer and light controller:
// state encodings, board size and light-position width.
package whack_scorer_pkg;

  localparam int NUM_LIGHTS  = 9;
  localparam int LIGHT_POS_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_HIT     = 3'd2,
    S_MISS    = 3'd3,
    S_LOCKOUT = 3'd4,
    S_OVER    = 3'd5
  } state_e;

  function automatic logic [NUM_LIGHTS-1:0] pos_mask(
    input logic [LIGHT_POS_W-1:0] pos
  );
    return NUM_LIGHTS'(1) << pos;
  endfunction

endpackage

// File: rtl/whack_scorer_if.sv
// Board/scorer bundle: buttons and lights in, score and strobes out.
// master drives the board side, slave is the scorer.
interface whack_scorer_if #(
  parameter int SCORE_W = 8,
  parameter int MISS_W  = 4
);
  import whack_scorer_pkg::*;

  logic [NUM_LIGHTS-1:0]  buttons;
  logic [NUM_LIGHTS-1:0]  lights;
  logic [LIGHT_POS_W-1:0] light_pos;
  logic                   game_en;
  logic [SCORE_W-1:0]     score;
  logic [MISS_W-1:0]      misses;
  logic                   hit_pulse;
  logic                   miss_pulse;
  logic                   game_over;

  modport master (
    output buttons, lights, light_pos, game_en,
    input  score, misses, hit_pulse, miss_pulse, game_over
  );

  modport slave (
    input  buttons, lights, light_pos, game_en,
    output score, misses, hit_pulse, miss_pulse, game_over
  );

endinterface

// File: rtl/whack_scorer_button_sync.sv
// N-bit two-flop synchroniser followed by a rising-edge detector.
// press is high for one cycle per synchronised 0->1 transition.
module button_sync #(
  parameter int N = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] in,
  output logic [N-1:0] press
);

  logic [N-1:0] meta;
  logic [N-1:0] sync;
  logic [N-1:0] sync_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta   <= '0;
      sync   <= '0;
      sync_d <= '0;
    end else begin
      meta   <= in;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign press = sync & ~sync_d;

endmodule

// File: rtl/whack_scorer.sv
// Mole hit/miss classifier with saturating score, miss count, game over.
// Optional: WHACK_IDLE_PENALTY_EN turns presses between moles into misses.
module whack_scorer
  import whack_scorer_pkg::*;
#(
  parameter int SCORE_W    = 8,
  parameter int MISS_W     = 4,
  parameter int MAX_MISSES = 3
) (
  input logic           clk,
  input logic           reset,
  whack_scorer_if.slave bus
);

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [MISS_W-1:0]  MISS_LIM  = MISS_W'(MAX_MISSES);

  logic [NUM_LIGHTS-1:0] press;

  state_e                state_q, state_n;
  logic [NUM_LIGHTS-1:0] tgt_q, tgt_n;
  logic [SCORE_W-1:0]    score_q, score_n;
  logic [MISS_W-1:0]     miss_q, miss_n;
  logic [MISS_W-1:0]     miss_inc;
  logic                  hit_q, hit_n;
  logic                  missp_q, missp_n;
  logic                  over_q, over_n;
  logic                  lights_on;
  logic                  wrong;
  logic                  right;

  button_sync #(
    .N(NUM_LIGHTS)
  ) u_sync (
    .clk  (clk),
    .reset(reset),
    .in   (bus.buttons),
    .press(press)
  );

  assign lights_on = |bus.lights;
  assign wrong     = |(press & ~tgt_q);
  assign right     = |(press & tgt_q);
  assign miss_inc  = miss_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      tgt_q   <= '0;
      score_q <= '0;
      miss_q  <= '0;
      hit_q   <= 1'b0;
      missp_q <= 1'b0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      tgt_q   <= tgt_n;
      score_q <= score_n;
      miss_q  <= miss_n;
      hit_q   <= hit_n;
      missp_q <= missp_n;
      over_q  <= over_n;
    end
  end

  always_comb begin
    state_n = state_q;
    tgt_n   = tgt_q;
    score_n = score_q;
    miss_n  = miss_q;
    hit_n   = 1'b0;
    missp_n = 1'b0;
    over_n  = over_q;
    if (state_q == S_OVER) begin
      over_n = 1'b1;
    end else if (!bus.game_en) begin
      state_n = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // A mole appearing wins over a coincident press.
          if (lights_on) begin
            tgt_n   = pos_mask(bus.light_pos);
            state_n = S_ARMED;
          end
`ifdef WHACK_IDLE_PENALTY_EN
          else if (|press) begin
            state_n = S_MISS;
          end
`endif
        end
        S_ARMED: begin
          if (wrong)           state_n = S_MISS;
          else if (right)      state_n = S_HIT;
          else if (!lights_on) state_n = S_MISS;
        end
        S_HIT: begin
          if (score_q != SCORE_MAX) score_n = score_q + 1'b1;
          hit_n   = 1'b1;
          state_n = S_LOCKOUT;
        end
        S_MISS: begin
          miss_n  = miss_inc;
          missp_n = 1'b1;
          if (miss_inc == MISS_LIM) begin
            over_n  = 1'b1;
            state_n = S_OVER;
          end else begin
            state_n = S_LOCKOUT;
          end
        end
        S_LOCKOUT: begin
          if (!lights_on) state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign bus.score      = score_q;
  assign bus.misses     = miss_q;
  assign bus.hit_pulse  = hit_q;
  assign bus.miss_pulse = missp_q;
  assign bus.game_over  = over_q;

endmodule

// File: tb/tb_whack_scorer.sv
// Self-checking bench for whack_scorer: table moles, hand sequences,
// random moles against a transaction-level scoring model.
module tb_whack_scorer;

  logic       clk;
  logic       reset;
  logic [8:0] buttons;
  logic [8:0] lights;
  logic [3:0] light_pos;
  logic       game_en;

  whack_scorer_if #(.SCORE_W(8), .MISS_W(4)) bus ();
  whack_scorer_if #(.SCORE_W(2), .MISS_W(4)) bus2 ();

  assign bus.buttons    = buttons;
  assign bus.lights     = lights;
  assign bus.light_pos  = light_pos;
  assign bus.game_en    = game_en;
  assign bus2.buttons   = buttons;
  assign bus2.lights    = lights;
  assign bus2.light_pos = light_pos;
  assign bus2.game_en   = game_en;

  whack_scorer #(
    .SCORE_W(8), .MISS_W(4), .MAX_MISSES(3)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus.slave)
  );

  whack_scorer #(
    .SCORE_W(2), .MISS_W(4), .MAX_MISSES(3)
  ) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;
  int hit_cnt;
  int miss_cnt;
  int hit2_cnt;

  // Model state: counts of verdicts, independent of counter widths.
  int m_score;
  int m_miss;
  bit m_over;

  always @(negedge clk) begin
    if (reset) begin
      hit_cnt  = hit_cnt + int'(bus.hit_pulse);
      miss_cnt = miss_cnt + int'(bus.miss_pulse);
      hit2_cnt = hit2_cnt + int'(bus2.hit_pulse);
    end
  end

  typedef struct {
    int         pos;
    logic [8:0] mask;
    int         hit;
    int         miss;
  } vec_t;

  vec_t tbl[5];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    buttons   = '0;
    lights    = '0;
    light_pos = '0;
    game_en   = 1'b1;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    m_score = 0;
    m_miss  = 0;
    m_over  = 1'b0;
  endtask

  task automatic play(int pos, logic [8:0] mask,
                      output int dh, output int dm, output int dh2);
    int h0, m0, h20;
    h0  = hit_cnt;
    m0  = miss_cnt;
    h20 = hit2_cnt;
    light_pos = 4'(pos);
    lights    = 9'(1) << pos;
    repeat (3) tick();
    buttons = mask;
    repeat (3) tick();
    buttons = '0;
    repeat (3) tick();
    lights = '0;
    repeat (6) tick();
    dh  = hit_cnt - h0;
    dm  = miss_cnt - m0;
    dh2 = hit2_cnt - h20;
  endtask

  function automatic int min_i(int a, int b);
    return (a < b) ? a : b;
  endfunction

  task automatic check_counters(string tag);
    chk({tag, "_score"}, int'(bus.score), min_i(m_score, 255));
    chk({tag, "_score2"}, int'(bus2.score), min_i(m_score, 3));
    chk({tag, "_misses"}, int'(bus.misses), m_miss);
    chk({tag, "_over"}, int'(bus.game_over), int'(m_over));
  endtask

  // Verdict rule: exactly the target button -> hit; anything else -> miss.
  task automatic mole(string tag, int pos, logic [8:0] mask,
                      output int eh, output int em);
    int dh, dm, dh2;
    eh = 0;
    em = 0;
    if (!m_over) begin
      if (mask == (9'(1) << pos)) eh = 1;
      else em = 1;
    end
    play(pos, mask, dh, dm, dh2);
    m_score += eh;
    m_miss  += em;
    if (m_miss == 3) m_over = 1'b1;
    chk({tag, "_hitp"}, dh, eh);
    chk({tag, "_missp"}, dm, em);
    chk({tag, "_hitp2"}, dh2, eh);
    check_counters(tag);
  endtask

  initial begin
    int eh, em, dh, dm, dh2, h0, m0;
    checks   = 0;
    failures = 0;
    hit_cnt  = 0;
    miss_cnt = 0;
    hit2_cnt = 0;
    reset    = 1'b0;

    tbl[0] = '{pos: 4, mask: 9'h010, hit: 1, miss: 0};
    tbl[1] = '{pos: 2, mask: 9'h080, hit: 0, miss: 1};
    tbl[2] = '{pos: 0, mask: 9'h000, hit: 0, miss: 1};
    tbl[3] = '{pos: 3, mask: 9'h028, hit: 0, miss: 1};
    tbl[4] = '{pos: 5, mask: 9'h020, hit: 0, miss: 0};

    do_reset();
    chk("rst_score", int'(bus.score), 0);
    chk("rst_misses", int'(bus.misses), 0);
    chk("rst_hitp", int'(bus.hit_pulse), 0);
    chk("rst_missp", int'(bus.miss_pulse), 0);
    chk("rst_over", int'(bus.game_over), 0);

    for (int i = 0; i < 5; i++) begin
      mole($sformatf("tbl%0d", i), tbl[i].pos, tbl[i].mask, eh, em);
      chk($sformatf("tbl%0d_exp_hit", i), eh, tbl[i].hit);
      chk($sformatf("tbl%0d_exp_miss", i), em, tbl[i].miss);
    end

    // Latency: button high at edge N -> pulse after edge N+3; hold = one hit.
    do_reset();
    light_pos = 4'd4;
    lights    = 9'h010;
    repeat (3) tick();
    h0 = hit_cnt;
    buttons = 9'h010;
    tick();
    tick();
    chk("lat_n1", int'(bus.hit_pulse), 0);
    tick();
    chk("lat_n2", int'(bus.hit_pulse), 0);
    tick();
    chk("lat_n3", int'(bus.hit_pulse), 1);
    chk("lat_score", int'(bus.score), 1);
    tick();
    chk("lat_n4", int'(bus.hit_pulse), 0);
    repeat (6) tick();
    buttons = '0;
    lights  = '0;
    repeat (5) tick();
    chk("lat_hold_hits", hit_cnt - h0, 1);

    // Wrong press then correct press on the same mole: one miss only.
    do_reset();
    h0 = hit_cnt;
    m0 = miss_cnt;
    light_pos = 4'd2;
    lights    = 9'h004;
    repeat (3) tick();
    buttons = 9'h080;
    repeat (3) tick();
    buttons = '0;
    repeat (3) tick();
    buttons = 9'h004;
    repeat (3) tick();
    buttons = '0;
    lights  = '0;
    repeat (5) tick();
    chk("late_hits", hit_cnt - h0, 0);
    chk("late_misses", miss_cnt - m0, 1);
    chk("late_cnt", int'(bus.misses), 1);

    // Correct press seen in the same cycle the mole disappears.
    do_reset();
    h0 = hit_cnt;
    m0 = miss_cnt;
    light_pos = 4'd7;
    lights    = 9'h080;
    repeat (3) tick();
    buttons = 9'h080;
    tick();
    tick();
    lights = '0;
    repeat (4) tick();
    buttons = '0;
    repeat (3) tick();
    chk("fall_hits", hit_cnt - h0, 1);
    chk("fall_misses", miss_cnt - m0, 0);

    // Press edge coincides with the mole appearing: press ignored.
    do_reset();
    h0 = hit_cnt;
    m0 = miss_cnt;
    buttons = 9'h002;
    tick();
    tick();
    light_pos = 4'd1;
    lights    = 9'h002;
    repeat (5) tick();
    lights = '0;
    repeat (4) tick();
    buttons = '0;
    tick();
    chk("rise_hits", hit_cnt - h0, 0);
    chk("rise_misses", miss_cnt - m0, 1);

    // Press between moles.
    do_reset();
    m0 = miss_cnt;
    buttons = 9'h008;
    repeat (3) tick();
    buttons = '0;
    repeat (5) tick();
`ifdef WHACK_IDLE_PENALTY_EN
    chk("idle_misses", miss_cnt - m0, 1);
    chk("idle_cnt", int'(bus.misses), 1);
`else
    chk("idle_misses", miss_cnt - m0, 0);
    chk("idle_cnt", int'(bus.misses), 0);
`endif

    // game_en low: no verdict, counters hold.
    do_reset();
    mole("en_pre", 4, 9'h010, eh, em);
    game_en = 1'b0;
    play(6, 9'h040, dh, dm, dh2);
    chk("en_off_hits", dh, 0);
    chk("en_off_misses", dm, 0);
    chk("en_off_score", int'(bus.score), 1);
    game_en = 1'b1;
    mole("en_post", 6, 9'h040, eh, em);

    // Saturation on the 2-bit instance: five hits, five pulses.
    do_reset();
    h0 = hit2_cnt;
    for (int i = 0; i < 5; i++)
      mole($sformatf("sat%0d", i), (i * 2) % 9,
           9'(1) << ((i * 2) % 9), eh, em);
    chk("sat_pulses2", hit2_cnt - h0, 5);
    chk("sat_score2", int'(bus2.score), 3);

    // Asynchronous reset in the middle of an armed mole.
    do_reset();
    mole("mid_pre", 1, 9'h002, eh, em);
    light_pos = 4'd6;
    lights    = 9'h040;
    repeat (3) tick();
    buttons = 9'h040;
    tick();
    #2 reset = 1'b0;
    #1;
    chk("mid_score", int'(bus.score), 0);
    chk("mid_misses", int'(bus.misses), 0);
    chk("mid_hitp", int'(bus.hit_pulse), 0);
    chk("mid_missp", int'(bus.miss_pulse), 0);
    chk("mid_over", int'(bus.game_over), 0);
    buttons = '0;
    lights  = '0;
    tick();
    reset = 1'b1;
    h0 = hit_cnt;
    m0 = miss_cnt;
    repeat (6) tick();
    chk("mid_rel_pulses", (hit_cnt - h0) + (miss_cnt - m0), 0);
    m_score = 0;
    m_miss  = 0;
    m_over  = 1'b0;
    check_counters("mid_rel");

    // Random moles against the model.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int k = 0; k < 12; k++) begin
        int pos, kind, w;
        logic [8:0] mask;
        pos  = $urandom_range(0, 8);
        kind = $urandom_range(0, 9);
        w    = (pos + 1 + $urandom_range(0, 7)) % 9;
        if (kind < 7)       mask = 9'(1) << pos;
        else if (kind == 7) mask = 9'(1) << w;
        else if (kind == 8) mask = (9'(1) << pos) | (9'(1) << w);
        else                mask = '0;
        mole($sformatf("rnd%0d_%0d", r, k), pos, mask, eh, em);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
